updown_sweep_ctrl: RTL and testbench

- Sweep sequencer built around a bidirectional counter.
- On start it latches a lower limit, an upper limit and a step size.
- It drives the count from lo up to hi and back down to lo (triangle sweep), clamping at both limits, then either finishes (one-shot) or repeats (continuous).
- Used in front of position or timer datapaths that need bounded, reversible count sequences with pause and abort control.

---
 rtl/updown_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
//
// Triangle sweep sequencer around a bidirectional counter. An accepted start
// latches lo/hi/step/mode. The count then runs lo -> hi -> lo in steps of
// `step`, clamping at both limits. After that the sweep either finishes
// (one-shot) or turns around and repeats (continuous).
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   start  : begin a sweep (sampled only while idle)
//   stop   : abort a running sweep; count and direction hold
//   pause  : freeze count, direction and state while high
//   mode   : 0 = one-shot, 1 = continuous (latched on accepted start)
//   lo     : lower limit (latched on accepted start)
//   hi     : upper limit (latched on accepted start)
//   step   : step size   (latched on accepted start)
//   count  : current count (registered)
//   up     : current direction, 1 = up (registered)
//   busy   : a sweep is in progress
//   done   : one-cycle pulse when a one-shot sweep lands on lo
//   err    : one-cycle pulse when a start is rejected (lo > hi or step == 0)
// -----------------------------------------------------------------------------
module updown_sweep_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] count,
   output logic             up,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_UP = 2'd1,
      RUN_DN = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n;
   logic             up_n, done_n, err_n;
   logic             accept;

   // Sweep parameters captured at the accepted start; inputs are ignored while busy.
   logic [WIDTH-1:0] lo_r, hi_r, step_r;
   logic             mode_r;

   // One extra bit so neither the upward sum nor the lower threshold can wrap.
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   lo_plus_step;

   assign sum_up       = {1'b0, count} + {1'b0, step_r};
   assign lo_plus_step = {1'b0, lo_r}  + {1'b0, step_r};

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block is assigned a default first so that no
      // path can leave a value unassigned and infer a latch.
      state_n = state;
      count_n = count;
      up_n    = up;
      done_n  = 1'b0;
      err_n   = 1'b0;
      accept  = 1'b0;

      unique case (state)
         IDLE: begin
            // start wins over stop here; stop has nothing to abort.
            if (start) begin
               if ((lo > hi) || (step == '0)) begin
                  err_n = 1'b1;
               end else begin
                  accept  = 1'b1;
                  count_n = lo;
                  up_n    = 1'b1;
                  state_n = RUN_UP;
               end
            end
         end

         RUN_UP: begin
            if (stop) begin
               state_n = IDLE;
            end else if (!pause) begin
               if (sum_up >= {1'b0, hi_r}) begin
                  count_n = hi_r;
                  up_n    = 1'b0;
                  state_n = RUN_DN;
               end else begin
                  count_n = sum_up[WIDTH-1:0];
               end
            end
         end

         RUN_DN: begin
            if (stop) begin
               state_n = IDLE;
            end else if (!pause) begin
               // Mirror of the upward clamp. A step that lands exactly on lo
               // counts as arriving at lo, so lo is never shown twice.
               if ({1'b0, count} <= lo_plus_step) begin
                  count_n = lo_r;
                  if (mode_r) begin
                     up_n    = 1'b1;
                     state_n = RUN_UP;
                  end else begin
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end
               end else begin
                  count_n = count - step_r;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State, output and parameter registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All registers
   // read their old values in the same edge, regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         up     <= 1'b1;
         done   <= 1'b0;
         err    <= 1'b0;
         // NOTE: the parameter registers are cleared on reset as well. Nothing
         // reads them in IDLE, but a known value keeps the sweep deterministic.
         lo_r   <= '0;
         hi_r   <= '0;
         step_r <= '0;
         mode_r <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         up    <= up_n;
         done  <= done_n;
         err   <= err_n;
         if (accept) begin
            lo_r   <= lo;
            hi_r   <= hi;
            step_r <= step;
            mode_r <= mode;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_sweep_ctrl
//
// Directed bench for updown_sweep_ctrl (WIDTH = 4). Inputs change 1 time unit
// after a rising edge, and outputs are sampled at that same point. Each step
// therefore shows the registers just loaded by the preceding edge.
// -----------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             start, stop, pause, mode;
   logic [WIDTH-1:0] lo, hi, step;
   logic [WIDTH-1:0] count;
   logic             up, busy, done, err;

   int checks = 0;
   int errors = 0;

   updown_sweep_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .stop  (stop),
      .pause (pause),
      .mode  (mode),
      .lo    (lo),
      .hi    (hi),
      .step  (step),
      .count (count),
      .up    (up),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Packed observation: {count[3:0], up, busy, done, err}
   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed {count,up,busy,done,err}=%h_%b%b%b%b expected %h_%b%b%b%b",
                tag, observed[7:4], observed[3], observed[2], observed[1], observed[0],
                expected[7:4], expected[3], expected[2], expected[1], expected[0]);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] c, input logic u,
                             input logic b, input logic d, input logic e);
      check(tag, {count, up, busy, done, err}, {c, u, b, d, e});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] l, input logic [3:0] h, input logic [3:0] s, input logic m);
      lo = l; hi = h; step = s; mode = m;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
      lo = '0; hi = '0; step = '0;

      #2;
      expect_out("reset_state", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      expect_out("idle_after_reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // ---- Basic one-shot 2..5 step 1; start held high while busy is ignored
      load(4'd2, 4'd5, 4'd1, 1'b0);
      start = 1'b1;
      tick(); expect_out("basic_c2",    4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      load(4'd0, 4'd15, 4'd3, 1'b1);   // junk parameters, must be ignored
      tick(); expect_out("basic_c3",    4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("basic_c4",    4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("basic_c5",    4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("basic_d4",    4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("basic_d3",    4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("basic_done2", 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      start = 1'b0;
      tick(); expect_out("basic_idle",  4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---- Clamping 1..10 step 4
      load(4'd1, 4'd10, 4'd4, 1'b0);
      start = 1'b1;
      tick(); expect_out("clamp_c1",    4'd1,  1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); expect_out("clamp_c5",    4'd5,  1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("clamp_c9",    4'd9,  1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("clamp_hi10",  4'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("clamp_d6",    4'd6,  1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("clamp_d2",    4'd2,  1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("clamp_done1", 4'd1,  1'b0, 1'b0, 1'b1, 1'b0);

      // ---- Rejected starts
      load(4'd6, 4'd3, 4'd1, 1'b0);
      start = 1'b1;
      tick(); expect_out("rej_lo_gt_hi",   4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
      tick(); expect_out("rej_err_clears", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      load(4'd1, 4'd3, 4'd0, 1'b0);
      start = 1'b1;
      tick(); expect_out("rej_step0",      4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
      tick(); expect_out("rej_step0_clr",  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---- Continuous 0..3 step 1 with pause, then stop
      load(4'd0, 4'd3, 4'd1, 1'b1);
      start = 1'b1;
      tick(); expect_out("cont_c0",     4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); expect_out("cont_c1",     4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("cont_c2",     4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      pause = 1'b1;
      tick(); expect_out("pause_1",     4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("pause_2",     4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("pause_3",     4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      pause = 1'b0;
      tick(); expect_out("cont_hi3",    4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("cont_d2",     4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("cont_d1",     4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("cont_turn0",  4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("cont_again1", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      stop = 1'b1;
      tick(); expect_out("stop_idle",   4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      stop = 1'b0;
      tick(); expect_out("stop_hold",   4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

      // ---- Degenerate range lo == hi == 7, start and stop together
      load(4'd7, 4'd7, 4'd2, 1'b0);
      start = 1'b1; stop = 1'b1;
      tick(); expect_out("degen_up",    4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0; stop = 1'b0;
      tick(); expect_out("degen_turn",  4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("degen_done",  4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); expect_out("degen_idle",  4'd7, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---- Large step near the top of the range must clamp, not wrap
      load(4'd12, 4'd15, 4'd15, 1'b0);
      start = 1'b1;
      tick(); expect_out("wide_c12",    4'd12, 1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); expect_out("wide_hi15",   4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("wide_done12", 4'd12, 1'b0, 1'b0, 1'b1, 1'b0);

      // ---- Asynchronous reset mid-sweep at count=4, going down
      load(4'd2, 4'd5, 4'd1, 1'b0);
      start = 1'b1;
      tick(); expect_out("ar_c2",       4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      tick(); tick(); tick();
      expect_out("ar_hi5",              4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); expect_out("ar_d4",       4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      expect_out("ar_immediate",        4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); expect_out("ar_held",     4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      tick(); tick();
      expect_out("ar_no_resume",        4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
